// File: rtl/arm7tdmi_pkg.sv
// Shared types and constants for the ARM7TDMI execute-stage operand logic.
package arm7tdmi_pkg;

    localparam int WORD_W      = 32;
    // Normalised shift amount: 0..255 from Rs, plus 32 for the LSR/ASR #0 encodings.
    localparam int SHIFT_AMT_W = 9;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_t;

    typedef enum logic {
        IDLE   = 1'b0,
        RSHIFT = 1'b1
    } op2_state_t;

    // A register-amount shift needs the extra internal cycle.
    // Bit 7 is not examined, so the multiply/extension space also lands here.
    function automatic logic is_reg_shift(input logic imm, input logic [11:0] field);
        return !imm && field[4];
    endfunction

endpackage

// File: rtl/arm7tdmi_op2_shift_core.sv
// Combinational ARM barrel shifter. Callers hand it an already normalised
// amount, so the immediate #0 special cases never reach this module.
module arm7tdmi_op2_shift_core
    import arm7tdmi_pkg::*;
(
    input  logic [WORD_W-1:0]      data_in,
    input  shift_type_t            shift_type,
    input  logic [SHIFT_AMT_W-1:0] shift_amt,
    input  logic                   rrx,
    input  logic                   carry_in,
    output logic [WORD_W-1:0]      data_out,
    output logic                   carry_out
);

    logic [4:0]        amt_lo;
    logic [4:0]        amt_m1;
    logic [4:0]        amt_inv;
    logic              amt_ge32;
    logic              amt_eq32;
    logic [WORD_W-1:0] lsl_res;
    logic [WORD_W-1:0] lsr_res;
    logic [WORD_W-1:0] asr_res;
    logic [WORD_W-1:0] ror_res;

    assign amt_lo   = shift_amt[4:0];
    assign amt_m1   = amt_lo - 5'd1;
    // 32 - amt for amt in 1..31; wraps to 0 when amt_lo is 0.
    assign amt_inv  = 5'd0 - amt_lo;
    assign amt_ge32 = |shift_amt[SHIFT_AMT_W-1:5];
    assign amt_eq32 = (shift_amt == SHIFT_AMT_W'(32));

    assign lsl_res = data_in << amt_lo;
    assign lsr_res = data_in >> amt_lo;
    assign asr_res = $signed(data_in) >>> amt_lo;
    assign ror_res = (data_in >> amt_lo) | (data_in << amt_inv);

    // Select result and carry; amount 0 (non-RRX) passes data and carry through.
    always_comb begin
        data_out  = data_in;
        carry_out = carry_in;
        if (rrx) begin
            data_out  = {carry_in, data_in[WORD_W-1:1]};
            carry_out = data_in[0];
        end else if (shift_amt != '0) begin
            case (shift_type)
                SHIFT_LSL: begin
                    if (!amt_ge32) begin
                        data_out  = lsl_res;
                        carry_out = data_in[amt_inv];
                    end else begin
                        data_out  = '0;
                        carry_out = amt_eq32 ? data_in[0] : 1'b0;
                    end
                end
                SHIFT_LSR: begin
                    if (!amt_ge32) begin
                        data_out  = lsr_res;
                        carry_out = data_in[amt_m1];
                    end else begin
                        data_out  = '0;
                        carry_out = amt_eq32 ? data_in[WORD_W-1] : 1'b0;
                    end
                end
                SHIFT_ASR: begin
                    if (!amt_ge32) begin
                        data_out  = asr_res;
                        carry_out = data_in[amt_m1];
                    end else begin
                        data_out  = {WORD_W{data_in[WORD_W-1]}};
                        carry_out = data_in[WORD_W-1];
                    end
                end
                default: begin
                    // Multiples of 32 leave data unchanged; amt_m1 wraps to 31,
                    // which is exactly the bit 31 carry those amounts need.
                    data_out  = ror_res;
                    carry_out = data_in[amt_m1];
                end
            endcase
        end
    end

endmodule

// File: rtl/arm7tdmi_operand2_unit.sv
// Operand2 producer: decodes the shifter operand field, runs the barrel
// shifter and hands Op2 plus shifter carry to the ALU over valid/ready.
// Register-amount shifts spend one extra cycle in RSHIFT.
module arm7tdmi_operand2_unit
    import arm7tdmi_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RS_AMT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              imm_flag,
    input  logic [11:0]       op2_field,
    input  logic [DATA_W-1:0] rm_data,
    input  logic [DATA_W-1:0] rs_data,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op2_out,
    output logic              shc_out,
    output logic              busy
);

    op2_state_t          state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic                shc_q, shc_d;

    logic                imm_q, imm_d;
    logic [11:0]         field_q, field_d;
    logic [DATA_W-1:0]   rm_q, rm_d;
    logic [RS_AMT_W-1:0] rs_q, rs_d;
    logic                cin_q, cin_d;

    logic                accept;
    logic                sel_imm;
    logic [11:0]         sel_field;
    logic [DATA_W-1:0]   sel_rm;
    logic [RS_AMT_W-1:0] sel_rs;
    logic                sel_cin;

    logic [WORD_W-1:0]      core_data;
    shift_type_t            core_type;
    logic [SHIFT_AMT_W-1:0] core_amt;
    logic                   core_rrx;
    logic [WORD_W-1:0]      core_res;
    logic                   core_carry;

    logic unused_rs_hi;
    assign unused_rs_hi = ^rs_data[DATA_W-1:RS_AMT_W];

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign op2_out   = op2_q;
    assign shc_out   = shc_q;
    assign busy      = (state_q == RSHIFT);

    // Capture the request operands on accept; RSHIFT works from these copies.
    always_comb begin
        imm_d   = imm_q;
        field_d = field_q;
        rm_d    = rm_q;
        rs_d    = rs_q;
        cin_d   = cin_q;
        if (accept) begin
            imm_d   = imm_flag;
            field_d = op2_field;
            rm_d    = rm_data;
            rs_d    = rs_data[RS_AMT_W-1:0];
            cin_d   = carry_in;
        end
    end

    // Single-cycle requests compute straight from the inputs; RSHIFT uses the copies.
    always_comb begin
        if (state_q == RSHIFT) begin
            sel_imm   = imm_q;
            sel_field = field_q;
            sel_rm    = rm_q;
            sel_rs    = rs_q;
            sel_cin   = cin_q;
        end else begin
            sel_imm   = imm_flag;
            sel_field = op2_field;
            sel_rm    = rm_data;
            sel_rs    = rs_data[RS_AMT_W-1:0];
            sel_cin   = carry_in;
        end
    end

    // Decode the operand field into shifter controls, folding the #0 encodings.
    always_comb begin
        core_data = sel_rm;
        core_type = shift_type_t'(sel_field[6:5]);
        core_amt  = '0;
        core_rrx  = 1'b0;
        if (sel_imm) begin
            core_data = {{(WORD_W-8){1'b0}}, sel_field[7:0]};
            core_type = SHIFT_ROR;
            core_amt  = {4'b0000, sel_field[11:8], 1'b0};
        end else if (sel_field[4]) begin
            core_amt = {{(SHIFT_AMT_W-RS_AMT_W){1'b0}}, sel_rs};
        end else if (sel_field[11:7] == 5'd0) begin
            case (shift_type_t'(sel_field[6:5]))
                SHIFT_LSR, SHIFT_ASR: core_amt = SHIFT_AMT_W'(32);
                SHIFT_ROR:            core_rrx = 1'b1;
                default:              core_amt = '0;
            endcase
        end else begin
            core_amt = {4'b0000, sel_field[11:7]};
        end
    end

    arm7tdmi_op2_shift_core u_shift_core (
        .data_in    (core_data),
        .shift_type (core_type),
        .shift_amt  (core_amt),
        .rrx        (core_rrx),
        .carry_in   (sel_cin),
        .data_out   (core_res),
        .carry_out  (core_carry)
    );

    // Next state and output register; flush beats both accept and RSHIFT completion.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        op2_d       = op2_q;
        shc_d       = shc_q;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_reg_shift(imm_flag, op2_field)) begin
                            state_d = RSHIFT;
                        end else begin
                            out_valid_d = 1'b1;
                            op2_d       = core_res;
                            shc_d       = core_carry;
                        end
                    end
                end
                default: begin
                    // Entry required a free output slot, so out_valid is already low here.
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    op2_d       = core_res;
                    shc_d       = core_carry;
                end
            endcase
        end
    end

    // State, output and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            op2_q       <= '0;
            shc_q       <= 1'b0;
            imm_q       <= 1'b0;
            field_q     <= '0;
            rm_q        <= '0;
            rs_q        <= '0;
            cin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            op2_q       <= op2_d;
            shc_q       <= shc_d;
            imm_q       <= imm_d;
            field_q     <= field_d;
            rm_q        <= rm_d;
            rs_q        <= rs_d;
            cin_q       <= cin_d;
        end
    end

endmodule

// File: tb/tb_arm7tdmi_operand2_unit.sv
// Self-checking bench for arm7tdmi_operand2_unit: directed cases, a random
// sweep against a bit-serial shift model, backpressure, flush and reset.
module tb_arm7tdmi_operand2_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        imm_flag;
    logic [11:0] op2_field;
    logic [31:0] rm_data;
    logic [31:0] rs_data;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op2_out;
    logic        shc_out;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] last_d;
    logic        last_c;

    always #5 clk = ~clk;

    arm7tdmi_operand2_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_flag  (imm_flag),
        .op2_field (op2_field),
        .rm_data   (rm_data),
        .rs_data   (rs_data),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op2_out   (op2_out),
        .shc_out   (shc_out),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: shift one bit at a time, carry = last bit shifted out.
    function automatic void ref_op2(input logic imm, input logic [11:0] f, input logic [31:0] rm,
                                    input logic [7:0] rs, input logic cin,
                                    output logic [31:0] r, output logic c);
        int n;
        int kind;
        logic is_rrx;
        r = rm;
        c = cin;
        is_rrx = 1'b0;
        if (imm) begin
            r    = {24'd0, f[7:0]};
            n    = 2 * int'(f[11:8]);
            kind = 3;
        end else begin
            kind = int'(f[6:5]);
            n    = f[4] ? int'(rs) : int'(f[11:7]);
            if (!f[4] && n == 0) begin
                if (kind == 1 || kind == 2) n = 32;
                else if (kind == 3) is_rrx = 1'b1;
            end
        end
        if (is_rrx) begin
            c = rm[0];
            r = {cin, rm[31:1]};
        end else begin
            for (int i = 0; i < n; i++) begin
                case (kind)
                    0: begin c = r[31]; r = r << 1; end
                    1: begin c = r[0];  r = r >> 1; end
                    2: begin c = r[0];  r = {r[31], r[31:1]}; end
                    default: begin c = r[0]; r = {r[0], r[31:1]}; end
                endcase
            end
        end
    endfunction

    // Issue one request from an idle, unstalled unit and check result and latency.
    task automatic run_op(input string tag, input logic imm, input logic [11:0] f,
                          input logic [31:0] rm, input logic [31:0] rs, input logic c);
        logic [31:0] exp_d;
        logic        exp_c;
        int          exp_lat;
        int          lat;
        ref_op2(imm, f, rm, rs[7:0], c, exp_d, exp_c);
        exp_lat   = (!imm && f[4]) ? 2 : 1;
        imm_flag  = imm;
        op2_field = f;
        rm_data   = rm;
        rs_data   = rs;
        carry_in  = c;
        in_valid  = 1'b1;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        rm_data   = $urandom;
        rs_data   = $urandom;
        op2_field = 12'($urandom);
        carry_in  = 1'($urandom);
        imm_flag  = 1'($urandom);
        chk({tag, ".busy"}, 32'(busy), 32'(exp_lat == 2));
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".op2"}, op2_out, exp_d);
        chk({tag, ".shc"}, 32'(shc_out), 32'(exp_c));
        last_d = exp_d;
        last_c = exp_c;
    endtask

    initial begin
        logic [11:0] f;
        logic [31:0] rm;
        logic [31:0] rs;
        logic        imm;
        logic [31:0] exp_d;
        logic        exp_c;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        imm_flag  = 1'b0;
        op2_field = '0;
        rm_data   = '0;
        rs_data   = '0;
        carry_in  = 1'b0;
        #23;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.op2", op2_out, 32'd0);
        chk("rst.shc", 32'(shc_out), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op("imm_4ff", 1'b1, 12'h4FF, 32'h0, 32'h0, 1'b0);
        chk("imm_4ff.val", op2_out, 32'hFF00_0000);
        run_op("rrx", 1'b0, 12'h060, 32'h3, 32'h0, 1'b1);
        chk("rrx.val", op2_out, 32'h8000_0001);
        run_op("lsl32", 1'b0, 12'h010, 32'h1, 32'd32, 1'b0);
        chk("lsl32.shc1", 32'(shc_out), 32'd1);
        run_op("lsl33", 1'b0, 12'h010, 32'h1, 32'd33, 1'b1);
        chk("lsl33.shc0", 32'(shc_out), 32'd0);
        run_op("asr200", 1'b0, 12'h050, 32'h8000_0000, 32'd200, 1'b0);
        chk("asr200.val", op2_out, 32'hFFFF_FFFF);
        run_op("ror64", 1'b0, 12'h070, 32'h8000_0001, 32'h40, 1'b0);
        chk("ror64.val", op2_out, 32'h8000_0001);
        run_op("lsr0imm", 1'b0, 12'h020, 32'h8000_0000, 32'h0, 1'b0);
        run_op("lsl0reg", 1'b0, 12'h010, 32'h1234_5678, 32'hFFFF_FF00, 1'b1);

        // Random sweep
        for (int k = 0; k < 300; k++) begin
            imm = 1'($urandom);
            f   = 12'($urandom);
            rm  = $urandom;
            rs  = $urandom;
            case ($urandom_range(0, 3))
                0: rs[7:0] = 8'($urandom_range(0, 33));
                1: rs[7:0] = 8'(32 * $urandom_range(0, 7));
                2: rs[7:0] = 8'($urandom_range(28, 36));
                default: ;
            endcase
            run_op("rand", imm, f, rm, rs, 1'($urandom));
        end

        // Backpressure then full-rate stream
        @(negedge clk);
        out_ready = 1'b0;
        ref_op2(1'b1, 12'h3AB, 32'h0, 8'h0, 1'b0, exp_d, exp_c);
        imm_flag  = 1'b1;
        op2_field = 12'h3AB;
        carry_in  = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.hold_op2", op2_out, exp_d);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            imm = 1'($urandom);
            f   = 12'($urandom);
            if (!imm) f[4] = 1'b0;
            rm  = $urandom;
            imm_flag  = imm;
            op2_field = f;
            rm_data   = rm;
            carry_in  = 1'($urandom);
            in_valid  = 1'b1;
            ref_op2(imm, f, rm, 8'h0, carry_in, exp_d, exp_c);
            #1;
            chk("stream.in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            chk("stream.valid", 32'(out_valid), 32'd1);
            chk("stream.op2", op2_out, exp_d);
            chk("stream.shc", 32'(shc_out), 32'(exp_c));
        end
        in_valid = 1'b0;
        last_d   = exp_d;
        last_c   = exp_c;
        @(negedge clk);
        chk("stream.drain", 32'(out_valid), 32'd0);

        // Flush during RSHIFT
        imm_flag  = 1'b0;
        op2_field = 12'h010;
        rm_data   = 32'hDEAD_BEEF;
        rs_data   = 32'd5;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("flush.busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush.valid", 32'(out_valid), 32'd0);
        chk("flush.busy_clr", 32'(busy), 32'd0);
        chk("flush.op2_kept", op2_out, last_d);
        chk("flush.shc_kept", 32'(shc_out), 32'(last_c));
        @(negedge clk);
        chk("flush.no_late", 32'(out_valid), 32'd0);

        // Flush together with a request
        imm_flag  = 1'b1;
        op2_field = 12'h0FF;
        flush     = 1'b1;
        in_valid  = 1'b1;
        #1;
        chk("flush_req.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_req.valid", 32'(out_valid), 32'd0);
        chk("flush_req.op2_kept", op2_out, last_d);

        // Asynchronous reset while in RSHIFT
        run_op("pre_rst", 1'b1, 12'h4FF, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        imm_flag  = 1'b0;
        op2_field = 12'h050;
        rm_data   = 32'h8000_0000;
        rs_data   = 32'd3;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_rs.busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rs.valid", 32'(out_valid), 32'd0);
        chk("rst_rs.busy", 32'(busy), 32'd0);
        chk("rst_rs.op2", op2_out, 32'd0);
        chk("rst_rs.shc", 32'(shc_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rs.after", 32'(out_valid), 32'd0);
        run_op("post_rst", 1'b0, 12'h0A0, 32'h8000_0001, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arm7tdmi_operand2_unit.md
Name: arm7tdmi_operand2_unit

Overview:
- Sequential producer of the data-processing second operand (Op2) and shifter carry for the ARM7TDMI execute stage.
- Decodes the 12-bit operand2 field and its I bit into an immediate rotate, an immediate-amount shift or a register-amount shift.
- Applies full ARM shift semantics, including amounts 0..255 from Rs.
- Register-specified shifts take the ARM7 extra internal cycle. Results go out over a valid/ready handshake to the ALU stage.

Parameters:
- DATA_W, 32, operand width; only 32 is supported.
- RS_AMT_W, 8, number of Rs bits used as the shift amount.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: asynchronous assert, active-low
- flush  in  1  synchronous abort from a pipeline flush
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- imm_flag  in  1  instruction I bit (bit 25)
- op2_field  in  12  instruction bits [11:0]
- rm_data  in  32  Rm value
- rs_data  in  32  Rs value; bits [7:0] used
- carry_in  in  1  CPSR C flag
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- op2_out  out  32  shifted operand
- shc_out  out  1  shifter carry-out
- busy  out  1  high while in state RSHIFT

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, op2_out=0, shc_out=0, busy=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- On accept, imm_flag, op2_field, rm_data, rs_data[7:0] and carry_in are registered. Inputs are don't-care at all other times.
- States:
  - IDLE: on accept of an immediate or immediate-shift request, compute and load the output register, set out_valid=1, stay in IDLE. Latency is 1 cycle from accept to out_valid.
  - IDLE: on accept of a register shift (imm_flag=0, op2_field[4]=1), go to RSHIFT.
  - RSHIFT: busy=1. Compute from the registered operands, load the output register, set out_valid=1, go to IDLE. Latency is 2 cycles.
- Output register holds its value while out_valid && !out_ready. out_valid clears on handshake unless a new result loads in the same cycle; back-to-back immediate requests reach 1 per cycle.
- flush:
  - Clears out_valid and returns to IDLE in the same clock edge.
  - Takes priority over accept and over RSHIFT completion; no result from that request is produced.
  - op2_out and shc_out keep their old values.
- Immediate (imm_flag=1):
  - rot = 2*op2_field[11:8]; op2_out = ROR(zero-extended op2_field[7:0], rot).
  - shc_out = carry_in if rot==0, else op2_out[31].
- Immediate shift (imm_flag=0, bit4=0): type = op2_field[6:5], amt = op2_field[11:7].
  - LSL #0: op2_out = Rm, shc_out = carry_in.
  - LSR #0 is executed as LSR #32; ASR #0 as ASR #32.
  - ROR #0 is RRX: op2_out = {carry_in, Rm[31:1]}, shc_out = Rm[0].
- Register shift: type = op2_field[6:5], amt = Rs[7:0].
  - amt==0 for any type: op2_out = Rm, shc_out = carry_in.
  - LSL 1..31: normal shift, shc_out = Rm[32-amt].
  - LSL 32: result 0, shc_out = Rm[0]. LSL >32: result 0, shc_out = 0.
  - LSR 1..31: normal shift, shc_out = Rm[amt-1].
  - LSR 32: result 0, shc_out = Rm[31]. LSR >32: result 0, shc_out = 0.
  - ASR 1..31: normal shift, shc_out = Rm[amt-1].
  - ASR >=32: result = {32{Rm[31]}}, shc_out = Rm[31].
  - ROR with amt[4:0]==0 (amt nonzero): op2_out = Rm, shc_out = Rm[31].
  - ROR otherwise: rotate by amt[4:0], shc_out = Rm[amt[4:0]-1].
- Bit 7 set together with bit 4 set (multiply/extension space) is out of scope. The block treats it as a register shift with no checking.

Decomposition:
- Shared arm7tdmi_pkg holds: shift_type_t enum (SHIFT_LSL, SHIFT_LSR, SHIFT_ASR, SHIFT_ROR), op2_state_t enum (IDLE, RSHIFT), constant WORD_W=32.
- One combinational sub-module, arm7tdmi_op2_shift_core. It takes data, type, a 9-bit normalised amount, an RRX flag and carry_in, and returns data and carry.
- The FSM and decode live in arm7tdmi_operand2_unit. Decode maps immediate #0 encodings to amount 32 or RRX before calling the core.

Test Plan:
- Immediate: imm_flag=1, op2_field=0x4FF, carry_in=0 -> out_valid 1 cycle after accept, op2_out=0xFF000000, shc_out=1.
- Immediate shift: op2_field=0x060 (ROR #0, RRX), Rm=0x00000003, carry_in=1 -> op2_out=0x80000001, shc_out=1, latency 1.
- Register shift: op2_field=0x010 (LSL Rs), Rs=32, Rm=0x00000001 -> busy 1 cycle, op2_out=0, shc_out=1, out_valid 2 cycles after accept. With Rs=33 -> op2_out=0, shc_out=0.
- Register ASR: op2_field=0x050, Rs=200, Rm=0x80000000 -> op2_out=0xFFFFFFFF, shc_out=1. Register ROR with Rs=0x40, Rm=0x80000001 -> op2_out unchanged, shc_out=1.
- Backpressure: out_ready=0 for 3 cycles after a result -> op2_out stable, in_ready=0. Raising out_ready with in_valid asserted -> accept and handshake in the same cycle, 1-per-cycle throughput.
- Flush and reset:
  - flush asserted in RSHIFT -> no out_valid, back in IDLE next cycle.
  - flush together with in_valid -> no accept.
  - rst_n pulsed low in RSHIFT -> outputs reset immediately, without waiting for clk.
